// File: rtl/rt_feed_pkg.sv
// Shared types and defaults for the RT feed sequencer.
package rt_feed_pkg;

  // Framing state: hunt for sync, read length, stream payload.
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5A5;
  localparam int          MAX_LEN_DEF   = 512;
  localparam int          CNT_W_DEF     = 16;

endpackage

// File: rtl/rt_feed_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;

  // Count increments, stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/rt_feed_sequencer.sv
// Drains the RX FIFO, frames sync/length/payload packets and hands payload
// words to the real-time consumer.
//
// Handshake: sample_valid, sample_data and sample_last are held stable from
// the cycle sample_valid rises until the cycle sample_valid && sample_ready is
// seen at a clock edge; the word is transferred on that edge and sample_valid
// drops in the following cycle. sample_valid never depends on sample_ready.
module rt_feed_sequencer
  import rt_feed_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          MAX_LEN   = MAX_LEN_DEF,
  parameter int          CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             fifo_rd_req,
  input  logic [15:0]      fifo_rd_data,
  input  logic             fifo_rd_empty,
  output logic [15:0]      sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             sample_last,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int          LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t             state_q;
  logic               rd_pend_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [15:0]        sample_data_q;
  logic               sample_valid_q;
  logic               sample_last_q;

  logic slot_ok;
  logic state_ok;
  logic rd_req;
  logic accept;
  logic bad_len;
  logic err_inc;
  logic pkt_inc;

  // Read issue: one read outstanding at most; in DATA wait for the output
  // slot to fully drain so the captured word always has somewhere to go.
  always_comb begin
    slot_ok  = !sample_valid_q || (sample_ready && (state_q != ST_DATA));
    state_ok = (state_q == ST_SYNC) ? enable : 1'b1;
    rd_req   = !reset && !fifo_rd_empty && !rd_pend_q && slot_ok && state_ok;
    accept   = sample_valid_q && sample_ready;
    bad_len  = (fifo_rd_data == 16'd0) || (fifo_rd_data > MAX_LEN_W);
    err_inc  = rd_pend_q &&
               (((state_q == ST_SYNC) && (fifo_rd_data != SYNC_WORD)) ||
                ((state_q == ST_LEN) && bad_len));
    pkt_inc  = accept && sample_last_q;
  end

  // Framing FSM, read-pending flag and registered payload outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_SYNC;
      rd_pend_q      <= 1'b0;
      remaining_q    <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      sample_last_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_req;

      if (accept) begin
        sample_valid_q <= 1'b0;
        sample_last_q  <= 1'b0;
        if (sample_last_q) begin
          state_q <= ST_SYNC;
        end
      end

      // A captured word is never concurrent with an accept: reads in DATA
      // are only issued while sample_valid is low.
      if (rd_pend_q) begin
        case (state_q)
          ST_SYNC: begin
            if (fifo_rd_data == SYNC_WORD) begin
              state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (bad_len) begin
              state_q <= ST_SYNC;
            end else begin
              remaining_q <= fifo_rd_data[LEN_W-1:0];
              state_q     <= ST_DATA;
            end
          end
          ST_DATA: begin
            sample_data_q  <= fifo_rd_data;
            sample_valid_q <= 1'b1;
            sample_last_q  <= (remaining_q == LEN_W'(1));
            remaining_q    <= remaining_q - 1'b1;
          end
          default: begin
            state_q <= ST_SYNC;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .inc_i   (pkt_inc),
    .count_o (pkt_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  assign fifo_rd_req  = rd_req;
  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign sample_last  = sample_last_q;
  assign busy         = (state_q != ST_SYNC) || rd_pend_q || sample_valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_rt_feed_sequencer.sv
// Directed bench for rt_feed_sequencer: FIFO model, beat scoreboard,
// vector table plus hand-written multi-cycle sequences.
module tb_rt_feed_sequencer;
  import rt_feed_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        enable;
  logic        fifo_rd_req;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_last;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic        busy;
  state_t      state_dbg;

  rt_feed_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_rd_req   (fifo_rd_req),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .sample_last   (sample_last),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // Narrow-counter instance fed a constant non-sync stream for saturation.
  logic        sat_enable;
  logic        sat_rd_req;
  logic [15:0] sat_sample_data;
  logic        sat_sample_valid;
  logic        sat_sample_last;
  logic [1:0]  sat_pkt;
  logic [1:0]  sat_err;
  logic        sat_busy;
  state_t      sat_state;

  rt_feed_sequencer #(.CNT_W(2)) u_sat (
    .clk           (clk),
    .reset         (reset),
    .enable        (sat_enable),
    .fifo_rd_req   (sat_rd_req),
    .fifo_rd_data  (16'h1234),
    .fifo_rd_empty (1'b0),
    .sample_data   (sat_sample_data),
    .sample_valid  (sat_sample_valid),
    .sample_ready  (1'b1),
    .sample_last   (sat_sample_last),
    .pkt_count     (sat_pkt),
    .err_count     (sat_err),
    .busy          (sat_busy),
    .state_dbg     (sat_state)
  );

  // ---------------- FIFO model (1-cycle read latency) ----------------
  logic [15:0] fq[$];

  always @(posedge clk) begin
    if (fifo_rd_req && (fq.size() > 0)) begin
      fifo_rd_data  <= fq.pop_front();
      fifo_rd_empty <= (fq.size() == 0);
    end
  end

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    fifo_rd_empty = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every accepted beat is matched in order against {last, data}.
  always @(negedge clk) begin
    if (!reset && sample_valid && sample_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got %0h expected none", {sample_last, sample_data});
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({sample_last, sample_data} !== e) begin
          failures++;
          $display("FAIL beat: got %0h expected %0h", {sample_last, sample_data}, e);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    logic tmo;
    n = 0;
    while (!(fifo_rd_empty && !busy) && (n < 300)) begin
      step();
      n++;
    end
    tmo = (n >= 300);
    check({name, "_timeout"}, 32'(tmo), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               n_in;
    logic [5:0][15:0] in_w;
    int               n_out;
    logic [3:0][16:0] out_w;
    int               d_err;
    int               d_pkt;
  } vec_t;

  vec_t vecs[7];
  int   exp_pkt;
  int   exp_err;

  initial begin
    // 3-word packet, last only on final word
    vecs[0].n_in = 5; vecs[0].in_w = '0;
    vecs[0].in_w[0] = 16'hA5A5; vecs[0].in_w[1] = 16'h0003; vecs[0].in_w[2] = 16'h1111;
    vecs[0].in_w[3] = 16'h2222; vecs[0].in_w[4] = 16'h3333;
    vecs[0].n_out = 3; vecs[0].out_w = '0;
    vecs[0].out_w[0] = {1'b0, 16'h1111}; vecs[0].out_w[1] = {1'b0, 16'h2222};
    vecs[0].out_w[2] = {1'b1, 16'h3333};
    vecs[0].d_err = 0; vecs[0].d_pkt = 1;
    // two garbage words before a 1-word packet
    vecs[1].n_in = 5; vecs[1].in_w = '0;
    vecs[1].in_w[0] = 16'h0000; vecs[1].in_w[1] = 16'h1234; vecs[1].in_w[2] = 16'hA5A5;
    vecs[1].in_w[3] = 16'h0001; vecs[1].in_w[4] = 16'hBEEF;
    vecs[1].n_out = 1; vecs[1].out_w = '0;
    vecs[1].out_w[0] = {1'b1, 16'hBEEF};
    vecs[1].d_err = 2; vecs[1].d_pkt = 1;
    // zero length
    vecs[2].n_in = 2; vecs[2].in_w = '0;
    vecs[2].in_w[0] = 16'hA5A5; vecs[2].in_w[1] = 16'h0000;
    vecs[2].n_out = 0; vecs[2].out_w = '0;
    vecs[2].d_err = 1; vecs[2].d_pkt = 0;
    // length 513, one over the limit
    vecs[3].n_in = 2; vecs[3].in_w = '0;
    vecs[3].in_w[0] = 16'hA5A5; vecs[3].in_w[1] = 16'h0201;
    vecs[3].n_out = 0; vecs[3].out_w = '0;
    vecs[3].d_err = 1; vecs[3].d_pkt = 0;
    // payload word equal to the sync word is plain data
    vecs[4].n_in = 4; vecs[4].in_w = '0;
    vecs[4].in_w[0] = 16'hA5A5; vecs[4].in_w[1] = 16'h0002; vecs[4].in_w[2] = 16'h0A0A;
    vecs[4].in_w[3] = 16'hA5A5;
    vecs[4].n_out = 2; vecs[4].out_w = '0;
    vecs[4].out_w[0] = {1'b0, 16'h0A0A}; vecs[4].out_w[1] = {1'b1, 16'hA5A5};
    vecs[4].d_err = 0; vecs[4].d_pkt = 1;
    // sync word in length slot is a bad length, not re-scanned
    vecs[5].n_in = 2; vecs[5].in_w = '0;
    vecs[5].in_w[0] = 16'hA5A5; vecs[5].in_w[1] = 16'hA5A5;
    vecs[5].n_out = 0; vecs[5].out_w = '0;
    vecs[5].d_err = 1; vecs[5].d_pkt = 0;
    // garbage then packet with length 1
    vecs[6].n_in = 4; vecs[6].in_w = '0;
    vecs[6].in_w[0] = 16'h1234; vecs[6].in_w[1] = 16'hA5A5; vecs[6].in_w[2] = 16'h0001;
    vecs[6].in_w[3] = 16'h0001;
    vecs[6].n_out = 1; vecs[6].out_w = '0;
    vecs[6].out_w[0] = {1'b1, 16'h0001};
    vecs[6].d_err = 1; vecs[6].d_pkt = 1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    logic tmo;

    reset         = 1'b1;
    enable        = 1'b0;
    sample_ready  = 1'b0;
    sat_enable    = 1'b0;
    fifo_rd_empty = 1'b1;
    fifo_rd_data  = 16'h0;
    exp_pkt       = 0;
    exp_err       = 0;

    repeat (3) step();
    check("rst_rd_req", 32'(fifo_rd_req), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_last", 32'(sample_last), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_pkt", 32'(pkt_count), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_SYNC));

    reset        = 1'b0;
    enable       = 1'b1;
    sample_ready = 1'b1;
    step();

    // ---- table-driven vectors ----
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < vecs[i].n_out; k++) exp_q.push_back(vecs[i].out_w[k]);
      for (int j = 0; j < vecs[i].n_in; j++) push(vecs[i].in_w[j]);
      wait_idle($sformatf("vec%0d", i));
      exp_pkt += vecs[i].d_pkt;
      exp_err += vecs[i].d_err;
      check($sformatf("vec%0d_pkt", i), 32'(pkt_count), 32'(exp_pkt));
      check($sformatf("vec%0d_err", i), 32'(err_count), 32'(exp_err));
      check($sformatf("vec%0d_pending", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(ST_SYNC));
    end

    // ---- backpressure on first payload word ----
    sample_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h1111});
    exp_q.push_back({1'b0, 16'h2222});
    exp_q.push_back({1'b1, 16'h3333});
    push(16'hA5A5); push(16'h0003); push(16'h1111); push(16'h2222); push(16'h3333);
    n = 0;
    while (!sample_valid && (n < 50)) begin step(); n++; end
    tmo = (n >= 50);
    check("bp_valid_timeout", 32'(tmo), 32'd0);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold_valid", 32'(sample_valid), 32'd1);
      check("bp_hold_data", 32'(sample_data), 32'h1111);
      check("bp_hold_last", 32'(sample_last), 32'd0);
      check("bp_no_read", 32'(fifo_rd_req), 32'd0);
      step();
    end
    sample_ready = 1'b1;
    wait_idle("bp");
    exp_pkt++;
    check("bp_pkt", 32'(pkt_count), 32'(exp_pkt));
    check("bp_pending", 32'(exp_q.size()), 32'd0);

    // ---- enable dropped mid-packet ----
    exp_q.push_back({1'b0, 16'h0011});
    exp_q.push_back({1'b0, 16'h0022});
    exp_q.push_back({1'b0, 16'h0033});
    exp_q.push_back({1'b1, 16'h0044});
    push(16'hA5A5); push(16'h0004);
    push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
    n = 0;
    while ((state_dbg != ST_DATA) && (n < 50)) begin step(); n++; end
    tmo = (n >= 50);
    check("en_data_timeout", 32'(tmo), 32'd0);
    enable = 1'b0;
    push(16'hA5A5);
    n = 0;
    while (busy && (n < 100)) begin step(); n++; end
    tmo = (n >= 100);
    check("en_drain_timeout", 32'(tmo), 32'd0);
    exp_pkt++;
    check("en_pkt", 32'(pkt_count), 32'(exp_pkt));
    check("en_pending", 32'(exp_q.size()), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("en_paused_rd", 32'(fifo_rd_req), 32'd0);
      step();
    end
    check("en_fifo_kept", 32'(fq.size()), 32'd1);
    enable = 1'b1;
    exp_q.push_back({1'b0, 16'h5555});
    exp_q.push_back({1'b1, 16'h6666});
    push(16'h0002); push(16'h5555); push(16'h6666);
    wait_idle("en_resume");
    exp_pkt++;
    check("en_resume_pkt", 32'(pkt_count), 32'(exp_pkt));
    check("en_resume_err", 32'(err_count), 32'(exp_err));
    check("en_resume_pending", 32'(exp_q.size()), 32'd0);

    // ---- reset while a DATA read is in flight ----
    push(16'hA5A5); push(16'h0003); push(16'h1111); push(16'h2222); push(16'h3333);
    n = 0;
    while (!((state_dbg == ST_DATA) && fifo_rd_req) && (n < 50)) begin step(); n++; end
    tmo = (n >= 50);
    check("rp_read_timeout", 32'(tmo), 32'd0);
    step();
    check("rp_busy_inflight", 32'(busy), 32'd1);
    reset = 1'b1;
    fq.delete();
    fifo_rd_empty = 1'b1;
    step();
    check("rp_rd_req", 32'(fifo_rd_req), 32'd0);
    check("rp_valid", 32'(sample_valid), 32'd0);
    check("rp_last", 32'(sample_last), 32'd0);
    check("rp_data", 32'(sample_data), 32'd0);
    check("rp_pkt", 32'(pkt_count), 32'd0);
    check("rp_err", 32'(err_count), 32'd0);
    check("rp_busy", 32'(busy), 32'd0);
    check("rp_state", 32'(state_dbg), 32'(ST_SYNC));
    reset = 1'b0;
    step();
    exp_q.push_back({1'b0, 16'hABCD});
    exp_q.push_back({1'b1, 16'h1357});
    push(16'hA5A5); push(16'h0002); push(16'hABCD); push(16'h1357);
    wait_idle("rp_fresh");
    check("rp_fresh_pkt", 32'(pkt_count), 32'd1);
    check("rp_fresh_err", 32'(err_count), 32'd0);
    check("rp_fresh_pending", 32'(exp_q.size()), 32'd0);

    // ---- counter saturation on the 2-bit instance ----
    sat_enable = 1'b1;
    repeat (40) step();
    check("sat_err", 32'(sat_err), 32'd3);
    check("sat_pkt", 32'(sat_pkt), 32'd0);
    check("sat_valid", 32'(sat_sample_valid), 32'd0);
    sat_enable = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
